// File: rtl/softmax_bram_pkg.sv
// Shared types and defaults for the softmax buffer BRAM arbiter.
package softmax_bram_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 1028;
    localparam int unsigned RD_LAT = 2;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_HOST = 1'b1
    } req_id_e;

    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
    } mem_cmd_t;

    // Host wins only if it is eligible and either the core is not, or the host is favoured.
    function automatic logic arb_pick_host(input logic core_elig, input logic host_elig,
                                           input req_id_e prio);
        return host_elig & (~core_elig | (prio == REQ_HOST));
    endfunction

endpackage

// File: rtl/bram_rd_return_pipe.sv
// Read-return tracker: shifts {valid, owner} alongside the BRAM port-B latency and
// raises a per-requester strobe in the cycle the read data is on i_mem_doutb.
module bram_rd_return_pipe
    import softmax_bram_pkg::*;
#(
    parameter int unsigned RD_LAT = softmax_bram_pkg::RD_LAT
) (
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  logic    i_valid,
    input  req_id_e i_owner,
    output logic    o_cap_c,
    output logic    o_cap_h
);

    // Stage 0 lines up with o_mem_cenb; stage RD_LAT lines up with valid doutb.
    logic [RD_LAT:0] r_valid;
    logic [RD_LAT:0] r_owner;

    // Shift register; reset discards every in-flight read.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_owner <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_owner[0] <= i_owner;
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_owner[i] <= r_owner[i-1];
            end
        end
    end

    // Decode the owner of the stage whose data is arriving now.
    always_comb begin
        o_cap_c = r_valid[RD_LAT] & (r_owner[RD_LAT] == REQ_CORE);
        o_cap_h = r_valid[RD_LAT] & (r_owner[RD_LAT] == REQ_HOST);
    end

endmodule

// File: rtl/softmax_bram_arbiter.sv
// Softmax buffer BRAM arbiter: host vs core on a write-only port A and a read-only
// port B, with busy lockout of the host and write-before-read hazard deferral.
// Optional round-robin arbitration: define SOFTMAX_BRAM_ARB_RR_EN.
module softmax_bram_arbiter
    import softmax_bram_pkg::*;
#(
    parameter int unsigned ADDR_W = softmax_bram_pkg::ADDR_W,
    parameter int unsigned DATA_W = softmax_bram_pkg::DATA_W,
    parameter int unsigned RD_LAT = softmax_bram_pkg::RD_LAT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_h_req,
    input  logic              i_h_we,
    input  logic [ADDR_W-1:0] i_h_addr,
    input  logic [DATA_W-1:0] i_h_din,
    output logic              o_h_gnt,
    output logic              o_h_rvalid,
    output logic [DATA_W-1:0] o_h_rdata,
    input  logic              i_c_req,
    input  logic              i_c_we,
    input  logic [ADDR_W-1:0] i_c_addr,
    input  logic [DATA_W-1:0] i_c_din,
    output logic              o_c_gnt,
    output logic              o_c_rvalid,
    output logic [DATA_W-1:0] o_c_rdata,
    input  logic              i_core_busy,
    output logic              o_mem_cena,
    output logic              o_mem_wea,
    output logic [ADDR_W-1:0] o_mem_addra,
    output logic [DATA_W-1:0] o_mem_dina,
    output logic              o_mem_cenb,
    output logic [ADDR_W-1:0] o_mem_addrb,
    input  logic [DATA_W-1:0] i_mem_doutb
);

    logic              w_c_wr, w_h_wr, w_c_rd, w_h_rd, w_c_rd_ok, w_h_rd_ok;
    logic              w_gnt_c_wr, w_gnt_h_wr, w_gnt_c_rd, w_gnt_h_rd;
    logic              w_wr_any, w_rd_any;
    logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
    req_id_e           w_rd_owner, w_prio_a, w_prio_b;
    mem_cmd_t          w_cmd_a, w_cmd_b, r_cmd_a, r_cmd_b;
    logic [DATA_W-1:0] r_dina, r_h_rdata, r_c_rdata;
    logic              r_h_rvalid, r_c_rvalid, w_cap_c, w_cap_h;

    // Eligibility; nothing is granted in a reset cycle.
    assign w_c_wr = i_rst_n & i_c_req & i_c_we;
    assign w_c_rd = i_rst_n & i_c_req & ~i_c_we;
    assign w_h_wr = i_rst_n & i_h_req & i_h_we & ~i_core_busy;
    assign w_h_rd = i_rst_n & i_h_req & ~i_h_we & ~i_core_busy;

`ifdef SOFTMAX_BRAM_ARB_RR_EN
    // Favoured requester per port, i.e. the one not granted last; core after reset.
    req_id_e r_prio_a, r_prio_b;

    // Round-robin pointers move only when their port grants.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prio_a <= REQ_CORE;
            r_prio_b <= REQ_CORE;
        end else begin
            if (w_wr_any) r_prio_a <= w_gnt_h_wr ? REQ_CORE : REQ_HOST;
            if (w_rd_any) r_prio_b <= w_gnt_h_rd ? REQ_CORE : REQ_HOST;
        end
    end

    assign w_prio_a = r_prio_a;
    assign w_prio_b = r_prio_b;
`else
    assign w_prio_a = REQ_CORE;
    assign w_prio_b = REQ_CORE;
`endif

    // Port A first, then port B with reads to the row being written held back.
    always_comb begin
        w_gnt_h_wr = arb_pick_host(w_c_wr, w_h_wr, w_prio_a);
        w_gnt_c_wr = w_c_wr & ~w_gnt_h_wr;
        w_wr_any   = w_gnt_c_wr | w_gnt_h_wr;
        w_wr_addr  = w_gnt_h_wr ? i_h_addr : i_c_addr;

        w_c_rd_ok  = w_c_rd & ~(w_wr_any & (w_wr_addr == i_c_addr));
        w_h_rd_ok  = w_h_rd & ~(w_wr_any & (w_wr_addr == i_h_addr));
        w_gnt_h_rd = arb_pick_host(w_c_rd_ok, w_h_rd_ok, w_prio_b);
        w_gnt_c_rd = w_c_rd_ok & ~w_gnt_h_rd;
        w_rd_any   = w_gnt_c_rd | w_gnt_h_rd;
        w_rd_addr  = w_gnt_h_rd ? i_h_addr : i_c_addr;
        w_rd_owner = w_gnt_h_rd ? REQ_HOST : REQ_CORE;

        w_cmd_a.en   = w_wr_any;
        w_cmd_a.we   = w_wr_any;
        w_cmd_a.addr = w_wr_any ? w_wr_addr : r_cmd_a.addr;
        w_cmd_b.en   = w_rd_any;
        w_cmd_b.we   = 1'b0;
        w_cmd_b.addr = w_rd_any ? w_rd_addr : r_cmd_b.addr;
    end

    assign o_h_gnt = w_gnt_h_wr | w_gnt_h_rd;
    assign o_c_gnt = w_gnt_c_wr | w_gnt_c_rd;

    // Registered memory commands; addresses and data hold while a port is idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cmd_a <= '0;
            r_cmd_b <= '0;
            r_dina  <= '0;
        end else begin
            r_cmd_a <= w_cmd_a;
            r_cmd_b <= w_cmd_b;
            if (w_wr_any) r_dina <= w_gnt_h_wr ? i_h_din : i_c_din;
        end
    end

    assign o_mem_cena  = r_cmd_a.en;
    assign o_mem_wea   = r_cmd_a.we;
    assign o_mem_addra = r_cmd_a.addr;
    assign o_mem_dina  = r_dina;
    assign o_mem_cenb  = r_cmd_b.en;
    assign o_mem_addrb = r_cmd_b.addr;

    bram_rd_return_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (w_rd_any),
        .i_owner (w_rd_owner),
        .o_cap_c (w_cap_c),
        .o_cap_h (w_cap_h)
    );

    // Capture read data for its owner; rdata holds until that owner's next return.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_h_rvalid <= 1'b0;
            r_c_rvalid <= 1'b0;
            r_h_rdata  <= '0;
            r_c_rdata  <= '0;
        end else begin
            r_h_rvalid <= w_cap_h;
            r_c_rvalid <= w_cap_c;
            if (w_cap_h) r_h_rdata <= i_mem_doutb;
            if (w_cap_c) r_c_rdata <= i_mem_doutb;
        end
    end

    assign o_h_rvalid = r_h_rvalid;
    assign o_h_rdata  = r_h_rdata;
    assign o_c_rvalid = r_c_rvalid;
    assign o_c_rdata  = r_c_rdata;

endmodule

// File: tb/tb_softmax_bram_arbiter.sv
// Directed bench for softmax_bram_arbiter with a scoreboard on the read returns
// and a behavioural 2-cycle-latency BRAM behind the memory ports.
module tb_softmax_bram_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 1028;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              h_req, h_we, c_req, c_we, core_busy;
    logic [ADDR_W-1:0] h_addr, c_addr;
    logic [DATA_W-1:0] h_din, c_din;
    logic              h_gnt, h_rvalid, c_gnt, c_rvalid;
    logic [DATA_W-1:0] h_rdata, c_rdata;
    logic              mem_cena, mem_wea, mem_cenb;
    logic [ADDR_W-1:0] mem_addra, mem_addrb;
    logic [DATA_W-1:0] mem_dina, mem_doutb;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_h[$];
    logic [DATA_W-1:0] exp_c[$];

    always #5 clk = ~clk;

    softmax_bram_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_h_req     (h_req),
        .i_h_we      (h_we),
        .i_h_addr    (h_addr),
        .i_h_din     (h_din),
        .o_h_gnt     (h_gnt),
        .o_h_rvalid  (h_rvalid),
        .o_h_rdata   (h_rdata),
        .i_c_req     (c_req),
        .i_c_we      (c_we),
        .i_c_addr    (c_addr),
        .i_c_din     (c_din),
        .o_c_gnt     (c_gnt),
        .o_c_rvalid  (c_rvalid),
        .o_c_rdata   (c_rdata),
        .i_core_busy (core_busy),
        .o_mem_cena  (mem_cena),
        .o_mem_wea   (mem_wea),
        .o_mem_addra (mem_addra),
        .o_mem_dina  (mem_dina),
        .o_mem_cenb  (mem_cenb),
        .o_mem_addrb (mem_addrb),
        .i_mem_doutb (mem_doutb)
    );

    // BRAM model: write on A, read on B with data two cycles after cenb.
    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] rd_s1, rd_s2;
    always @(posedge clk) begin
        if (mem_cena && mem_wea) mem[mem_addra] <= mem_dina;
        if (mem_cenb) rd_s1 <= mem[mem_addrb];
        rd_s2 <= rd_s1;
    end
    assign mem_doutb = rd_s2;

    function automatic logic [DATA_W-1:0] pat(input logic [7:0] b);
        logic [1031:0] t;
        t = {129{b}};
        return t[DATA_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic drive_h(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        h_req = 1'b1; h_we = we; h_addr = a; h_din = d;
    endtask

    task automatic drive_c(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        c_req = 1'b1; c_we = we; c_addr = a; c_din = d;
    endtask

    // Scoreboard monitor: every rvalid pulse must match the oldest expected return.
    initial begin : monitor
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (h_rvalid) begin
                checks++;
                if (exp_h.size() == 0) begin
                    errors++;
                    $display("FAIL h_rvalid: got unexpected pulse, want none");
                end else begin
                    e = exp_h.pop_front();
                    if (h_rdata !== e) begin
                        errors++;
                        $display("FAIL h_rdata: got %h want %h", h_rdata[63:0], e[63:0]);
                    end
                end
            end
            if (c_rvalid) begin
                checks++;
                if (exp_c.size() == 0) begin
                    errors++;
                    $display("FAIL c_rvalid: got unexpected pulse, want none");
                end else begin
                    e = exp_c.pop_front();
                    if (c_rdata !== e) begin
                        errors++;
                        $display("FAIL c_rdata: got %h want %h", c_rdata[63:0], e[63:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [3:0] exp_cseq;
`ifdef SOFTMAX_BRAM_ARB_RR_EN
        exp_cseq = 4'b0101;
`else
        exp_cseq = 4'b1111;
`endif
        rst_n = 1'b0; core_busy = 1'b0;
        h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_din = '0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_din = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        smp;
        chk("rst_cena", mem_cena, 0);
        chk("rst_wea", mem_wea, 0);
        chk("rst_cenb", mem_cenb, 0);
        chk("rst_h_rvalid", h_rvalid, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_addra", mem_addra, 0);
        nxt;

        // Host write row 3.
        drive_h(1'b1, 5'd3, pat(8'hA5));
        smp; chk("wr3_h_gnt", h_gnt, 1); chk("wr3_c_gnt", c_gnt, 0);
        nxt; h_req = 1'b0;
        smp; chk("wr3_cena", mem_cena, 1); chk("wr3_wea", mem_wea, 1);
        chk("wr3_addra", mem_addra, 3); chk("wr3_dina", mem_dina[31:0], 32'hA5A5A5A5);
        chk("wr3_cenb", mem_cenb, 0);
        nxt; smp; chk("wr3_cena_pulse", mem_cena, 0);
        nxt;

        // Host read row 3: rvalid exactly at T+4.
        drive_h(1'b0, 5'd3, '0);
        smp; chk("rd3_h_gnt", h_gnt, 1); exp_h.push_back(pat(8'hA5));
        nxt; h_req = 1'b0;
        smp; chk("rd3_cenb", mem_cenb, 1); chk("rd3_addrb", mem_addrb, 3);
        nxt; nxt;
        smp; chk("rd3_rvalid_t3", h_rvalid, 0);
        nxt;
        smp; chk("rd3_rvalid_t4", h_rvalid, 1); chk("rd3_c_rvalid", c_rvalid, 0);
        nxt;

        // Write contention: core first, host next cycle.
        drive_c(1'b1, 5'd10, pat(8'h3C));
        drive_h(1'b1, 5'd11, pat(8'hC3));
        smp; chk("wcon_c_gnt", c_gnt, 1); chk("wcon_h_gnt", h_gnt, 0);
        nxt; c_req = 1'b0;
        smp; chk("wcon_h_gnt2", h_gnt, 1); chk("wcon_addra", mem_addra, 10);
        nxt; h_req = 1'b0;
        smp; chk("wcon_addra2", mem_addra, 11);
        nxt;

        // Repeated write contention.
        drive_c(1'b1, 5'd20, pat(8'h01));
        drive_h(1'b1, 5'd21, pat(8'h02));
        for (int i = 0; i < 4; i++) begin
            smp;
            chk("rep_c_gnt", c_gnt, 32'(exp_cseq[i]));
            chk("rep_h_gnt", h_gnt, 32'(!exp_cseq[i]));
            nxt;
        end
        c_req = 1'b0; h_req = 1'b0;

        // Read contention: back-to-back returns in issue order.
        drive_c(1'b0, 5'd10, '0);
        drive_h(1'b0, 5'd11, '0);
        smp; chk("rcon_c_gnt", c_gnt, 1); chk("rcon_h_gnt", h_gnt, 0);
        exp_c.push_back(pat(8'h3C));
        nxt; c_req = 1'b0;
        smp; chk("rcon_h_gnt2", h_gnt, 1); exp_h.push_back(pat(8'hC3));
        nxt; h_req = 1'b0;
        repeat (4) nxt;

        // Write and read to different rows in one cycle.
        drive_c(1'b1, 5'd12, pat(8'h66));
        drive_h(1'b0, 5'd3, '0);
        smp; chk("par_c_gnt", c_gnt, 1); chk("par_h_gnt", h_gnt, 1);
        exp_h.push_back(pat(8'hA5));
        nxt; c_req = 1'b0; h_req = 1'b0;
        smp; chk("par_cena", mem_cena, 1); chk("par_cenb", mem_cenb, 1);
        repeat (4) nxt;

        // Same-row hazard: host read deferred, returns the new data.
        drive_h(1'b1, 5'd7, pat(8'h11));
        smp; chk("hz_pre_gnt", h_gnt, 1);
        nxt; h_req = 1'b0;
        nxt;
        drive_c(1'b1, 5'd7, pat(8'h5C));
        drive_h(1'b0, 5'd7, '0);
        smp; chk("hz_c_gnt", c_gnt, 1); chk("hz_h_gnt", h_gnt, 0);
        nxt; c_req = 1'b0;
        smp; chk("hz_h_gnt2", h_gnt, 1); exp_h.push_back(pat(8'h5C));
        nxt; h_req = 1'b0;
        repeat (5) nxt;

        // Busy lockout; core still served, row 31 used as the top boundary.
        core_busy = 1'b1;
        drive_h(1'b1, 5'd5, pat(8'h77));
        drive_c(1'b1, 5'd31, pat(8'hE7));
        for (int i = 0; i < 5; i++) begin
            smp;
            chk("busy_h_gnt", h_gnt, 0);
            if (i == 0) chk("busy_c_gnt", c_gnt, 1);
            nxt;
            c_req = 1'b0;
        end
        core_busy = 1'b0;
        smp; chk("unbusy_h_gnt", h_gnt, 1);
        nxt; h_req = 1'b0;

        // Boundary rows 31 and 0.
        drive_c(1'b0, 5'd31, '0);
        smp; chk("r31_c_gnt", c_gnt, 1); exp_c.push_back(pat(8'hE7));
        nxt; c_req = 1'b0;
        drive_h(1'b1, 5'd0, pat(8'h0F));
        smp; chk("w0_h_gnt", h_gnt, 1);
        nxt; h_req = 1'b0;
        drive_c(1'b0, 5'd0, '0);
        smp; chk("r0_c_gnt", c_gnt, 1); exp_c.push_back(pat(8'h0F));
        nxt; c_req = 1'b0;
        repeat (5) nxt;

        // Reset at T+2 of an outstanding host read: no return may appear.
        drive_h(1'b0, 5'd3, '0);
        smp; chk("rst_rd_gnt", h_gnt, 1);
        nxt; h_req = 1'b0;
        nxt; rst_n = 1'b0;
        nxt; rst_n = 1'b1;
        smp; chk("postrst_cena", mem_cena, 0); chk("postrst_cenb", mem_cenb, 0);
        chk("postrst_h_rvalid", h_rvalid, 0); chk("postrst_h_rdata", h_rdata[31:0], 0);
        repeat (6) nxt;

        chk("exp_h_empty", exp_h.size(), 0);
        chk("exp_c_empty", exp_c.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_bram_arbiter.md
Name: softmax_bram_arbiter

Overview:
- Shares the softmax buffer BRAM between two requesters: the host side (UART loader/unloader) and the softmax core.
- The BRAM is dual-port: port A is write-only, port B is read-only, both 1028-bit, 32 rows.
- Arbitrates each port independently, one command per port per cycle.
- Blocks host access while the core is busy, resolves same-address read/write hazards, and returns read data with a valid pulse to the owning requester.

Parameters:
- ADDR_W, 5, BRAM row address width.
- DATA_W, 1028, BRAM row width in bits.
- RD_LAT, 2, BRAM port-B latency in cycles, from the cycle o_mem_cenb is high to the cycle i_mem_doutb is valid.

Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_h_req  in  1  host command request.
- i_h_we  in  1  host command type: 1 = write, 0 = read.
- i_h_addr  in  ADDR_W  host row address.
- i_h_din  in  DATA_W  host write data.
- o_h_gnt  out  1  host command accepted this cycle (combinational).
- o_h_rvalid  out  1  host read data valid (one-cycle pulse).
- o_h_rdata  out  DATA_W  host read data.
- i_c_req, i_c_we, i_c_addr, i_c_din, o_c_gnt, o_c_rvalid, o_c_rdata: core requester; same widths and meaning as the host set.
- i_core_busy  in  1  core owns the BRAM; host is locked out while high.
- o_mem_cena  out  1  port A enable.
- o_mem_wea  out  1  port A write enable.
- o_mem_addra  out  ADDR_W  port A address.
- o_mem_dina  out  DATA_W  port A write data.
- o_mem_cenb  out  1  port B enable.
- o_mem_addrb  out  ADDR_W  port B address.
- i_mem_doutb  in  DATA_W  port B read data.

Behaviour:
- Reset, sampled at the clock edge while i_rst_n is low:
  - All outputs go to 0.
  - Read-return pipeline is flushed; in-flight reads are discarded and no rvalid is generated for them.
  - Arbitration pointer returns to core.
- Request handshake:
  - A requester holds req, we, addr and din stable until it sees gnt high in the same cycle.
  - The command is accepted at that clock edge.
  - The requester may present a new command in the next cycle.
  - A requester issues at most one command per cycle.
- Write arbitration (port A):
  - Candidates are requesters with req=1 and we=1; the host is excluded while i_core_busy=1.
  - Default policy is fixed priority, core over host.
- Read arbitration (port B): same candidate rule with we=0, same policy as port A.
- Concurrency: a write from one requester and a read from the other are both granted in the same cycle, except for the hazard case below.
- Hazard:
  - Condition: a granted write and a read candidate target the same address in the same cycle.
  - The read is not granted that cycle and is re-arbitrated next cycle, so it returns the new data.
- Memory command timing:
  - Gnt in cycle T → the mem port signals are registered and high in cycle T+1.
  - cena/wea/cenb are single-cycle pulses; they are 0 when the port is idle.
  - addra/dina/addrb hold their last value when the port is idle.
- Read return:
  - A (valid, owner) entry is shifted through an RD_LAT+1 stage pipeline.
  - i_mem_doutb is captured in cycle T+1+RD_LAT.
  - o_x_rvalid and o_x_rdata are registered and appear in cycle T+2+RD_LAT (T+4 at default RD_LAT).
  - o_x_rdata holds its value until the next return to that requester.
  - Returns are delivered in issue order; back-to-back reads give back-to-back rvalid pulses.
- i_core_busy:
  - When it rises, no further host grants are issued from that cycle on.
  - Host commands already granted complete normally, including their read returns.
  - A pending host req simply waits, with gnt held at 0.
- Address range: the full 0..2^ADDR_W-1 range is legal; there is no wrap or clamp.

Optional Feature:
- Macro: SOFTMAX_BRAM_ARB_RR_EN.
- When defined:
  - Each port uses round-robin arbitration with a 1-bit last-granted pointer per port.
  - When both requesters are eligible, the one not granted last on that port wins.
  - The pointer updates only on a grant.
  - The i_core_busy lockout still overrides round-robin.
- When undefined: fixed priority, core over host; no pointer flops are instantiated.

Decomposition:
- Package softmax_bram_pkg holds:
  - ADDR_W, DATA_W and RD_LAT defaults.
  - Requester-id enum: REQ_CORE=0, REQ_HOST=1.
  - A mem-command struct {en, we, addr}.
- Sub-module bram_rd_return_pipe: parameterised RD_LAT shift register carrying {valid, owner id}; outputs the owner-decoded capture strobe.

Test Plan:
- Host writes row 3 with 0xA5 pattern, idle core → o_h_gnt=1 in T; o_mem_cena=o_mem_wea=1 and addra=3 in T+1.
- Host reads row 3 → o_h_rvalid pulse at T+4, o_h_rdata equals the row written; o_c_rvalid stays 0.
- Core and host both write in the same cycle, macro off → core granted; host granted the next cycle. Macro on, repeated contention → grants alternate.
- Core writes row 7 while host reads row 7 in the same cycle → host read deferred one cycle and returns the new data.
- i_core_busy=1 while host continuously requests → o_h_gnt=0 throughout; host granted the first cycle after busy falls.
- i_rst_n low for one cycle at T+2 of an outstanding read → no rvalid ever appears; all mem enables are 0 the cycle after reset.
